ro_puf_core: RTL and testbench
==============================

// Module: ro_puf_core
// PURPOSE
//   Parametrised ring-oscillator PUF response generator. Successor to the single-bit
//   challenge/response core.
//   - Takes a serially loaded multi-bit challenge.
//   - For each response bit, selects a pair of oscillator inputs, counts their rising
//     edges over a fixed window and compares the two counts.
//   - Assembles RESP_BITS response bits and returns them behind a start/valid handshake.
//   Sits between the oscillator array and the chip I/O wrapper.
// PARAMETERS
//   NUM_RO    16    number of oscillator inputs; power of 2, >=4; SEL_W = log2(NUM_RO)
//   RESP_BITS 8     response width in bits, >=1
//   WIN_CYC   1024  counting window length in clk cycles, >=4
//   CNT_W     16    edge-counter width; counters saturate at 2^CNT_W-1
// PORTS
//   clk        in   1          system clock
//   rst_n      in   1          asynchronous active-low reset
//   osc_in     in   NUM_RO     raw oscillator outputs, asynchronous to clk
//   chal_in    in   1          serial challenge data bit
//   chal_load  in   1          shifts chal_in into the challenge register, MSB-first
//   start      in   1          1-cycle pulse; begins response generation
//   busy       out  1          high while a response is being generated
//   resp_valid out  1          resp holds a completed response
//   resp       out  RESP_BITS  response; bit i = comparison i
//   unstable   out  1          sticky vote-disagreement flag (VOTE_EN only; else tied 0)
// BEHAVIOUR
//   - Reset (async assert, sync deassert by the system): all outputs 0, FSM = IDLE,
//     challenge register = 0, counters = 0.
//   - Oscillator path: each osc_in bit passes a 2-flop synchroniser, then a rising-edge
//     detector (one pulse per sync'd 0->1).
//     - Edges already in the synchroniser when COUNT starts may be counted. This is accepted.
//   - Challenge register: CHAL_W = 2*SEL_W bits.
//     - In IDLE, chal_load does chal <= {chal[CHAL_W-2:0], chal_in}.
//     - chal_load is ignored when not in IDLE.
//     - chal_load is ignored when start is high in the same cycle; start has priority.
//   - Pair selection for bit i (mod NUM_RO):
//     - a = chal[SEL_W-1:0] + i
//     - b = chal[CHAL_W-1:SEL_W] + i
//     - if a == b then b = a + 1
//   - FSM, per comparison:
//     - IDLE: start -> CLEAR. Sets busy=1 and clears resp_valid, resp and unstable.
//     - CLEAR: 1 cycle; both counters <= 0; edges are ignored.
//     - COUNT: exactly WIN_CYC cycles; cntA/cntB += edge[a]/edge[b]; saturating.
//     - COMPARE: 1 cycle; bit = (cntA > cntB); a tie gives 0.
//       - More comparisons pending -> CLEAR.
//       - Last comparison -> IDLE: resp_valid<=1 and busy<=0 on the same edge.
//   - Latency: start sampled at edge t.
//     - Without VOTE_EN: resp_valid rises at edge t + RESP_BITS*(WIN_CYC+2).
//     - With VOTE_EN: the multiplier is 3x.
//   - resp and resp_valid hold until the next accepted start. start while busy is ignored.
//   - Reset mid-operation aborts immediately to the reset state. No partial response
//     is retained.
// CONFIGURATION
//   PUF_VOTE_EN
//   - Defined:
//     - Each response bit is measured 3 times (3 CLEAR/COUNT/COMPARE passes).
//     - The bit is the majority of the 3 results.
//     - unstable is set (sticky until next start) if the 3 votes of any bit disagree.
//   - Undefined:
//     - Single measurement per bit.
//     - Vote logic is absent; unstable is constant 0.
// TESTING
//   Bench parameters: NUM_RO=4, RESP_BITS=4, WIN_CYC=32, CNT_W=4.
//   Oscillator rising-edge periods: RO0=4, RO1=8, RO2=16, RO3=6 cycles.
//   - Basic: load 4'b0100, start. Expected resp=4'b0011 with resp_valid at start+136,
//     busy high for those 136 cycles.
//   - Collision: load 4'b0000 (a==b, so b=a+1), start. Expected resp=4'b0011.
//   - Saturation/tie: RO0 and RO1 both at period 2, load 4'b0100.
//     Counts saturate at 15, so bit0 = 0.
//   - Busy rules: pulse start and chal_load mid-run. Expected: no restart and chal
//     unchanged (read back via a second run). resp_valid holds 4'b0011 until the next
//     start.
//   - Reset mid-COUNT: assert rst_n=0 at start+50. Expected: busy, resp_valid and resp
//     all 0 immediately, and a new run after release gives 4'b0011.
//   - PUF_VOTE_EN: Basic scenario. Expected resp=4'b0011 at start+408 with unstable=0.
//     Then jitter RO2/RO3 to equal rates; the bench checks unstable=1.

Source files
------------

// File: rtl/ro_puf_core.sv
// ro_puf_core -- ring-oscillator PUF response generator.
//
// Loads a serial challenge, then measures RESP_BITS oscillator pairs. For each
// pair it counts synchronised rising edges over a WIN_CYC-cycle window and
// compares the two counts. The assembled response is returned behind a
// start/busy/valid handshake.
//
// Build option: define PUF_VOTE_EN to measure every bit three times and take
// the majority; unstable_o then flags any bit whose three votes disagreed.
// Without the macro each bit is measured once and unstable_o is tied low.
//
// Ports:
//   clk_i          system clock
//   rst_n_i        asynchronous active-low reset
//   osc_in_i       raw oscillator outputs (asynchronous to clk_i)
//   chal_in_i      serial challenge bit
//   chal_load_i    shift chal_in_i into the challenge register (MSB-first, IDLE only)
//   start_i        one-cycle pulse starting response generation
//   busy_o         high while a response is being generated
//   resp_valid_o   resp_o holds a completed response
//   resp_o         response; bit i is comparison i
//   unstable_o     sticky vote-disagreement flag (vote build only)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; challenge register may be shifted
// CLEAR   | one cycle, both edge counters zeroed, window timer loaded
// COUNT   | WIN_CYC cycles accumulating edges of oscillators a and b
// COMPARE | one cycle, records cntA > cntB and picks the next pass/bit

module ro_puf_core #(
    parameter int NUM_RO    = 16,
    parameter int RESP_BITS = 8,
    parameter int WIN_CYC   = 1024,
    parameter int CNT_W     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [NUM_RO-1:0]    osc_in_i,
    input  logic                 chal_in_i,
    input  logic                 chal_load_i,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 resp_valid_o,
    output logic [RESP_BITS-1:0] resp_o,
    output logic                 unstable_o
);

    localparam int SEL_W  = $clog2(NUM_RO);
    localparam int CHAL_W = 2 * SEL_W;
    localparam int BIT_W  = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int IDX_W  = (BIT_W > SEL_W) ? BIT_W : SEL_W;
    localparam int WIN_W  = $clog2(WIN_CYC);

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(RESP_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_COUNT   = 2'd2,
        ST_COMPARE = 2'd3
    } state_t;

    state_t                 state_q;
    logic [CHAL_W-1:0]      chal_q;
    logic [BIT_W-1:0]       bit_q;
    logic [WIN_W-1:0]       win_q;
    logic [CNT_W-1:0]       cnt_a_q;
    logic [CNT_W-1:0]       cnt_b_q;
    logic                   busy_q;
    logic                   valid_q;
    logic [RESP_BITS-1:0]   resp_q;

    // Oscillator synchroniser (two flops) plus one more stage for edge detect.
    logic [NUM_RO-1:0] sync1_q, sync2_q, sync3_q;
    logic [NUM_RO-1:0] osc_edge;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= osc_in_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign osc_edge = sync2_q & ~sync3_q;

    // Pair selection: both challenge halves offset by the bit index, modulo
    // NUM_RO (power of two, so truncation does the wrap). A self-pair would
    // always tie, so b is bumped to the next oscillator.
    logic [IDX_W-1:0] bit_ext, sum_a, sum_b;
    logic [SEL_W-1:0] sel_a, sel_b_raw, sel_b;

    assign bit_ext   = IDX_W'(bit_q);
    assign sum_a     = IDX_W'(chal_q[SEL_W-1:0]) + bit_ext;
    assign sum_b     = IDX_W'(chal_q[CHAL_W-1:SEL_W]) + bit_ext;
    assign sel_a     = sum_a[SEL_W-1:0];
    assign sel_b_raw = sum_b[SEL_W-1:0];
    assign sel_b     = (sel_a == sel_b_raw) ? (sel_a + SEL_W'(1)) : sel_b_raw;

    logic cmp_bit;
    logic bit_done;
    logic bit_val;

    assign cmp_bit = (cnt_a_q > cnt_b_q);

`ifdef PUF_VOTE_EN
    logic [1:0] vote_q;
    logic [1:0] votes_q;
    logic       unstable_q;
    logic       disagree;

    // The third pass is the current comparison; the first two are stored.
    assign bit_done = (vote_q == 2'd2);
    assign bit_val  = (votes_q[0] & votes_q[1]) | (votes_q[0] & cmp_bit) |
                      (votes_q[1] & cmp_bit);
    assign disagree = !((votes_q[0] == votes_q[1]) && (votes_q[1] == cmp_bit));
    assign unstable_o = unstable_q;
`else
    assign bit_done   = 1'b1;
    assign bit_val    = cmp_bit;
    assign unstable_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            chal_q  <= '0;
            bit_q   <= '0;
            win_q   <= '0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            resp_q  <= '0;
`ifdef PUF_VOTE_EN
            vote_q     <= 2'd0;
            votes_q    <= 2'b00;
            unstable_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_CLEAR;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
                        resp_q  <= '0;
                        bit_q   <= '0;
`ifdef PUF_VOTE_EN
                        vote_q     <= 2'd0;
                        unstable_q <= 1'b0;
`endif
                    end else if (chal_load_i) begin
                        chal_q <= {chal_q[CHAL_W-2:0], chal_in_i};
                    end
                end

                ST_CLEAR: begin
                    cnt_a_q <= '0;
                    cnt_b_q <= '0;
                    win_q   <= WIN_LAST;
                    state_q <= ST_COUNT;
                end

                ST_COUNT: begin
                    if (osc_edge[sel_a] && (cnt_a_q != CNT_MAX)) begin
                        cnt_a_q <= cnt_a_q + 1'b1;
                    end
                    if (osc_edge[sel_b] && (cnt_b_q != CNT_MAX)) begin
                        cnt_b_q <= cnt_b_q + 1'b1;
                    end
                    if (win_q == '0) begin
                        state_q <= ST_COMPARE;
                    end else begin
                        win_q <= win_q - 1'b1;
                    end
                end

                ST_COMPARE: begin
                    if (!bit_done) begin
`ifdef PUF_VOTE_EN
                        votes_q[vote_q[0]] <= cmp_bit;
                        vote_q             <= vote_q + 2'd1;
`endif
                        state_q <= ST_CLEAR;
                    end else begin
                        resp_q[bit_q] <= bit_val;
`ifdef PUF_VOTE_EN
                        vote_q <= 2'd0;
                        if (disagree) begin
                            unstable_q <= 1'b1;
                        end
`endif
                        if (bit_q == BIT_LAST) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            state_q <= ST_CLEAR;
                        end
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign resp_valid_o = valid_q;
    assign resp_o       = resp_q;

endmodule

// File: tb/tb_ro_puf_core.sv
module tb_ro_puf_core;

    localparam int NUM_RO    = 4;
    localparam int RESP_BITS = 4;
    localparam int WIN_CYC   = 32;
    localparam int CNT_W     = 4;
`ifdef PUF_VOTE_EN
    localparam int PASSES = 3;
`else
    localparam int PASSES = 1;
`endif
    localparam int EXP_LAT = RESP_BITS * (WIN_CYC + 2) * PASSES;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_RO-1:0]    osc = '0;
    logic                 chal_in = 1'b0;
    logic                 chal_load = 1'b0;
    logic                 start = 1'b0;
    logic                 busy;
    logic                 resp_valid;
    logic [RESP_BITS-1:0] resp;
    logic                 unstable;

    ro_puf_core #(
        .NUM_RO   (NUM_RO),
        .RESP_BITS(RESP_BITS),
        .WIN_CYC  (WIN_CYC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .osc_in_i    (osc),
        .chal_in_i   (chal_in),
        .chal_load_i (chal_load),
        .start_i     (start),
        .busy_o      (busy),
        .resp_valid_o(resp_valid),
        .resp_o      (resp),
        .unstable_o  (unstable)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Oscillator stimulus: periodic square waves (period in clk cycles) or
    // random toggling when jitter is enabled, updated on the falling edge.
    int per[NUM_RO];
    int ph[NUM_RO];
    bit jit[NUM_RO];

    always @(negedge clk) begin
        for (int k = 0; k < NUM_RO; k++) begin
            if (jit[k]) begin
                osc[k] = 1'($urandom_range(0, 1));
            end else begin
                ph[k] = (ph[k] + 1 >= per[k]) ? 0 : ph[k] + 1;
                osc[k] = (ph[k] < per[k] / 2);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic set_per(input int p0, input int p1, input int p2, input int p3);
        per[0] = p0; per[1] = p1; per[2] = p2; per[3] = p3;
    endtask

    task automatic load_chal(input logic [3:0] c);
        for (int i = 3; i >= 0; i--) begin
            @(negedge clk);
            chal_load = 1'b1;
            chal_in   = c[i];
        end
        @(negedge clk);
        chal_load = 1'b0;
        chal_in   = 1'b0;
    endtask

    // Starts a run and waits (bounded) for resp_valid. poke_at > 0 pulses
    // start and chal_load together that many cycles into the run.
    task automatic run(input int poke_at, output logic [3:0] r, output int lat,
                       output bit busy_ok);
        busy_ok = 1'b1;
        lat     = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!busy) busy_ok = 1'b0;
        while (lat < EXP_LAT + 50) begin
            @(negedge clk);
            start     = 1'b0;
            chal_load = 1'b0;
            if (poke_at != 0 && lat == poke_at) begin
                start     = 1'b1;
                chal_load = 1'b1;
                chal_in   = 1'b1;
            end
            @(posedge clk);
            #1;
            lat++;
            if (resp_valid) break;
            if (!busy) busy_ok = 1'b0;
        end
        r = resp;
        @(negedge clk);
        start     = 1'b0;
        chal_load = 1'b0;
        chal_in   = 1'b0;
    endtask

    // Reference: expected edges per window is WIN_CYC/period, clipped at the
    // counter ceiling; bit = strictly more edges on a than on b.
    function automatic int nominal(input int p);
        int n;
        n = WIN_CYC / p;
        return (n > CNT_SAT) ? CNT_SAT : n;
    endfunction

    function automatic logic [3:0] model(input logic [3:0] c);
        logic [3:0] m;
        int a, b;
        m = '0;
        for (int i = 0; i < RESP_BITS; i++) begin
            a = (int'(c[1:0]) + i) % NUM_RO;
            b = (int'(c[3:2]) + i) % NUM_RO;
            if (a == b) b = (a + 1) % NUM_RO;
            m[i] = (nominal(per[a]) > nominal(per[b]));
        end
        return m;
    endfunction

    typedef struct {
        string      name;
        logic [3:0] chal;
        int         p0, p1, p2, p3;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [3:0] r;
        int lat;
        bit bok;
        bit hold_ok;
        logic [3:0] c;
        int tmp, j;
        bit seen;

        vecs[0] = '{"basic",     4'b0100, 4, 8, 16, 6, 4'b0011};
        vecs[1] = '{"collision", 4'b0000, 4, 8, 16, 6, 4'b0011};
        vecs[2] = '{"saturate",  4'b0100, 2, 2, 16, 6, 4'b0010};
        vecs[3] = '{"chal1000",  4'b1000, 4, 8, 16, 6, 4'b1001};
        vecs[4] = '{"chal0001",  4'b0001, 4, 8, 16, 6, 4'b1100};

        for (int k = 0; k < NUM_RO; k++) begin
            ph[k]  = 0;
            jit[k] = 1'b0;
        end
        set_per(4, 8, 16, 6);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_resp", 32'(resp), 32'd0);
        check("rst_unstable", 32'(unstable), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven vectors
        for (int v = 0; v < 5; v++) begin
            set_per(vecs[v].p0, vecs[v].p1, vecs[v].p2, vecs[v].p3);
            repeat (4) @(negedge clk);
            load_chal(vecs[v].chal);
            run(0, r, lat, bok);
            check({vecs[v].name, "_resp"}, 32'(r), 32'(vecs[v].exp));
            check({vecs[v].name, "_lat"}, 32'(lat), 32'(EXP_LAT));
            check({vecs[v].name, "_busy_run"}, 32'(bok), 32'd1);
            check({vecs[v].name, "_busy_end"}, 32'(busy), 32'd0);
            check({vecs[v].name, "_unstable"}, 32'(unstable), 32'd0);
        end

        // Start and chal_load while busy are ignored; result holds until next start
        set_per(4, 8, 16, 6);
        load_chal(4'b0100);
        run(50, r, lat, bok);
        check("busyrule_resp", 32'(r), 32'h3);
        check("busyrule_lat", 32'(lat), 32'(EXP_LAT));
        hold_ok = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (!(resp_valid && resp == 4'b0011 && !busy)) hold_ok = 1'b0;
        end
        check("busyrule_hold", 32'(hold_ok), 32'd1);
        run(0, r, lat, bok);
        check("busyrule_chal_kept", 32'(r), 32'h3);

        // Reset mid-COUNT
        load_chal(4'b0100);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (48) @(negedge clk);
        check("midrst_busy_before", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(resp_valid), 32'd0);
        check("midrst_resp", 32'(resp), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(0, r, lat, bok);
        check("midrst_rerun", 32'(r), 32'h3);
        check("midrst_lat", 32'(lat), 32'(EXP_LAT));

        // Random challenges and period assignments against the reference model
        for (int n = 0; n < 8; n++) begin
            set_per(4, 8, 16, 6);
            for (int i = NUM_RO - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = per[i]; per[i] = per[j]; per[j] = tmp;
            end
            c = 4'($urandom_range(0, 15));
            repeat (4) @(negedge clk);
            load_chal(c);
            run(0, r, lat, bok);
            check($sformatf("rand%0d_resp_c%0h", n, c), 32'(r), 32'(model(c)));
            check($sformatf("rand%0d_lat", n), 32'(lat), 32'(EXP_LAT));
        end

        // Jittered equal-rate pair
        set_per(4, 8, 16, 6);
        jit[2] = 1'b1;
        jit[3] = 1'b1;
`ifdef PUF_VOTE_EN
        seen = 1'b0;
        for (int n = 0; n < 8 && !seen; n++) begin
            load_chal(4'b0100);
            run(0, r, lat, bok);
            if (unstable) seen = 1'b1;
        end
        check("vote_unstable", 32'(seen), 32'd1);
        run(0, r, lat, bok);
        set_per(4, 8, 16, 6);
`else
        seen = 1'b0;
        for (int n = 0; n < 3; n++) begin
            load_chal(4'b0100);
            run(0, r, lat, bok);
            if (unstable) seen = 1'b1;
        end
        check("novote_unstable_tied", 32'(seen), 32'd0);
`endif
        jit[2] = 1'b0;
        jit[3] = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
